// File: rtl/mem_io_responder.sv
// Responder for the core's byte-wide RAM/IO bus: synchronous byte RAM plus an IO window
// (addr[17:16]==2'b11) holding the UART TX FIFO, the RX holding register and the sim-end port.
module mem_io_responder #(
    parameter int RAM_ADDR_W   = 17,
    parameter int TX_DEPTH_LOG = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_r_w,
    input  logic [31:0] ram_addr,
    input  logic [7:0]  ram_w_data,
    output logic [7:0]  ram_r_data,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_done,
    output logic [7:0]  exit_code,
    output logic        tx_overflow
);

    localparam int DEPTH = 1 << TX_DEPTH_LOG;
    localparam int CNT_W = TX_DEPTH_LOG + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] NEAR_FULL_CNT = CNT_W'(DEPTH - 2);

    logic [7:0]              mem [2**RAM_ADDR_W];
    logic [7:0]              tx_mem [DEPTH];
    logic [TX_DEPTH_LOG-1:0] wr_ptr;
    logic [TX_DEPTH_LOG-1:0] rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_nxt;
    logic                    rx_full;
    logic                    rx_full_nxt;
    logic [7:0]              rx_byte;
    logic                    prev_data_rd;
    logic [7:0]              r_data_nxt;

    logic is_io, off_data, off_ctrl;
    logic ram_wr, ram_rd, io_wr_data, io_wr_ctrl, io_rd_data, io_rd_ctrl;
    logic tx_pop, push_ok, push_drop, rx_pop, rx_cap;
    logic unused_addr;

    // Only addr[17:16], addr[2:0] and the RAM index matter; the rest of the bus is ignored.
    assign unused_addr = ^ram_addr;

    assign is_io    = (ram_addr[17:16] == 2'b11);
    assign off_data = (ram_addr[2:0] == 3'd0);
    assign off_ctrl = (ram_addr[2:0] == 3'd4);

    assign ram_wr     = ram_r_w & ~is_io & ~rst;
    assign ram_rd     = ~ram_r_w & ~is_io;
    assign io_wr_data = ram_r_w & is_io & off_data;
    assign io_wr_ctrl = ram_r_w & is_io & off_ctrl;
    assign io_rd_data = ~ram_r_w & is_io & off_data;
    assign io_rd_ctrl = ~ram_r_w & is_io & off_ctrl;

    assign tx_valid  = (count != '0);
    assign tx_data   = tx_mem[rd_ptr];
    assign tx_pop    = tx_valid & tx_ready;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok   = io_wr_data & ((count != DEPTH_CNT) | tx_pop);
    assign push_drop = io_wr_data & ~push_ok;

    // The RX register is consumed only by the first cycle of a data-read burst.
    assign rx_pop      = io_rd_data & ~prev_data_rd;
    assign rx_cap      = rx_valid & rx_ready;
    assign rx_full_nxt = rx_cap | (rx_full & ~rx_pop);

    always_comb begin
        count_nxt = count;
        if (push_ok && !tx_pop) begin
            count_nxt = count + 1'b1;
        end else if (!push_ok && tx_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    always_comb begin
        r_data_nxt = 8'h00;
        if (ram_rd) begin
            r_data_nxt = mem[ram_addr[RAM_ADDR_W-1:0]];
        end else if (io_rd_data) begin
            r_data_nxt = rx_pop ? (rx_full ? rx_byte : 8'h00) : ram_r_data;
        end else if (io_rd_ctrl) begin
            r_data_nxt = {6'b0, rx_full, io_buffer_full};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr[RAM_ADDR_W-1:0]] <= ram_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            tx_mem[wr_ptr] <= ram_w_data;
        end
    end

    // Flag rises two entries early so a write already in flight still fits.
    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            count          <= count_nxt;
            io_buffer_full <= (count_nxt >= NEAR_FULL_CNT);
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_drop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_r_data   <= 8'h00;
            rx_full      <= 1'b0;
            rx_byte      <= 8'h00;
            rx_ready     <= 1'b0;
            prev_data_rd <= 1'b0;
            program_done <= 1'b0;
            exit_code    <= 8'h00;
        end else begin
            ram_r_data   <= r_data_nxt;
            rx_full      <= rx_full_nxt;
            rx_ready     <= ~rx_full_nxt;
            prev_data_rd <= io_rd_data;
            program_done <= io_wr_ctrl;
            if (rx_cap) begin
                rx_byte <= rx_data;
            end
            if (io_wr_ctrl) begin
                exit_code <= ram_w_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: queue/array reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_io_responder;

    localparam int DEPTH = 16;
    localparam logic [31:0] IDLE_ADDR = 32'h0003_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_r_w;
    logic [31:0] ram_addr;
    logic [7:0]  ram_w_data;
    logic [7:0]  ram_r_data;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_done;
    logic [7:0]  exit_code;
    logic        tx_overflow;

    always #5 clk = ~clk;

    mem_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH_LOG(4)) dut (
        .clk(clk), .rst(rst), .ram_r_w(ram_r_w), .ram_addr(ram_addr),
        .ram_w_data(ram_w_data), .ram_r_data(ram_r_data), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_done(program_done), .exit_code(exit_code), .tx_overflow(tx_overflow)
    );

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte map for RAM, queue for the TX FIFO, plain flags for RX/ctrl.
    logic [7:0] m_mem [int];
    logic [7:0] m_txq [$];
    logic       m_valid = 1'b0;
    logic       m_rd_known, m_overflow, m_buf_full, m_rx_has, m_rx_ready, m_done, m_prev_data_rd;
    logic [7:0] m_rx_byte, m_rdata, m_exit;

    always @(posedge clk) begin : model_update
        logic       io;
        logic [2:0] off;
        logic       rd_data, first, known;
        logic [7:0] nxt;
        int         idx;
        if (rst) begin
            m_txq.delete();
            m_valid = 1'b1; m_rd_known = 1'b1; m_rdata = 8'h00;
            m_overflow = 1'b0; m_buf_full = 1'b0; m_rx_has = 1'b0; m_rx_ready = 1'b0;
            m_done = 1'b0; m_exit = 8'h00; m_prev_data_rd = 1'b0; m_rx_byte = 8'h00;
        end else begin
            io      = (ram_addr[17:16] == 2'b11);
            off     = ram_addr[2:0];
            idx     = int'(ram_addr[16:0]);
            rd_data = !ram_r_w && io && off == 3'd0;
            first   = rd_data && !m_prev_data_rd;
            known   = 1'b1;
            nxt     = 8'h00;
            if (!ram_r_w && !io) begin
                known = m_mem.exists(idx);
                nxt   = known ? m_mem[idx] : 8'h00;
            end else if (rd_data) begin
                nxt = first ? (m_rx_has ? m_rx_byte : 8'h00) : m_rdata;
                known = first ? 1'b1 : m_rd_known;
            end else if (!ram_r_w && io && off == 3'd4) begin
                nxt = {6'b0, m_rx_has, m_buf_full};
            end
            if (ram_r_w && !io) m_mem[idx] = ram_w_data;
            if (m_txq.size() > 0 && tx_ready) void'(m_txq.pop_front());
            if (ram_r_w && io && off == 3'd0) begin
                if (m_txq.size() < DEPTH) m_txq.push_back(ram_w_data);
                else m_overflow = 1'b1;
            end
            m_buf_full = (m_txq.size() >= DEPTH - 2);
            m_done = ram_r_w && io && off == 3'd4;
            if (m_done) m_exit = ram_w_data;
            if (first) m_rx_has = 1'b0;
            if (rx_valid && m_rx_ready) begin
                m_rx_has  = 1'b1;
                m_rx_byte = rx_data;
            end
            m_rx_ready     = !m_rx_has;
            m_prev_data_rd = rd_data;
            m_rdata        = nxt;
            m_rd_known     = known;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            if (m_rd_known) checkOutput("ram_r_data", ram_r_data, m_rdata);
            checkOutput("io_buffer_full", io_buffer_full, m_buf_full);
            checkOutput("tx_valid", tx_valid, m_txq.size() > 0);
            if (m_txq.size() > 0) checkOutput("tx_data", tx_data, m_txq[0]);
            checkOutput("rx_ready", rx_ready, m_rx_ready);
            checkOutput("program_done", program_done, m_done);
            checkOutput("exit_code", exit_code, m_exit);
            checkOutput("tx_overflow", tx_overflow, m_overflow);
        end
    end

    // Drive one bus cycle, then return at the following negedge with its results visible.
    task automatic applyStimulus(input logic r, input logic rw, input logic [31:0] a,
                                 input logic [7:0] wd, input logic txr,
                                 input logic rv, input logic [7:0] rd);
        rst = r; ram_r_w = rw; ram_addr = a; ram_w_data = wd;
        tx_ready = txr; rx_valid = rv; rx_data = rd;
        @(negedge clk);
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [7:0] d, input logic txr);
        applyStimulus(1'b0, 1'b1, a, d, txr, 1'b0, 8'h00);
    endtask

    task automatic busRead(input logic [31:0] a, input logic txr);
        applyStimulus(1'b0, 1'b0, a, 8'h00, txr, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, IDLE_ADDR, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    logic [31:0] pool [8];
    logic [31:0] a;
    logic        rw, r, txr, rv;
    logic [7:0]  wd, rd;
    int          sel;

    initial begin
        pool[0] = 32'h0000_0200; pool[1] = 32'h0000_1ABC; pool[2] = 32'h0001_FFFF;
        pool[3] = 32'h0002_0123; pool[4] = 32'h0002_FFFE; pool[5] = 32'h0001_0000;
        pool[6] = 32'h0000_0000; pool[7] = 32'h0000_0103;
        rst = 1'b1; ram_r_w = 1'b0; ram_addr = IDLE_ADDR; ram_w_data = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        doReset();
        doReset();
        checkOutput("rst_ram_r_data", ram_r_data, 8'h00);
        checkOutput("rst_rx_ready", rx_ready, 1'b0);
        checkOutput("rst_tx_valid", tx_valid, 1'b0);
        checkOutput("rst_io_buffer_full", io_buffer_full, 1'b0);
        checkOutput("rst_exit_code", exit_code, 8'h00);
        busRead(IDLE_ADDR, 1'b0);
        checkOutput("rx_ready_after_rst", rx_ready, 1'b1);

        // RAM write then back-to-back reads
        busWrite(32'h100, 8'h12, 1'b0); busWrite(32'h101, 8'h34, 1'b0);
        busWrite(32'h102, 8'h56, 1'b0); busWrite(32'h103, 8'h78, 1'b0);
        busRead(32'h100, 1'b0); checkOutput("t1_rd100", ram_r_data, 8'h12);
        busRead(32'h101, 1'b0); checkOutput("t1_rd101", ram_r_data, 8'h34);
        busRead(32'h102, 1'b0); checkOutput("t1_rd102", ram_r_data, 8'h56);
        busRead(32'hFFFC_0103, 1'b0); checkOutput("t1_rd103_alias", ram_r_data, 8'h78);

        // TX back-pressure and overflow
        for (int i = 0; i < 17; i++) begin
            busWrite(32'h0003_0000, 8'(8'h10 + i), 1'b0);
            if (i == 12) checkOutput("t2_full_after13", io_buffer_full, 1'b0);
            if (i == 13) checkOutput("t2_full_after14", io_buffer_full, 1'b1);
            if (i == 15) checkOutput("t2_ovf_after16", tx_overflow, 1'b0);
        end
        checkOutput("t2_ovf_after17", tx_overflow, 1'b1);
        for (int k = 0; k < 16; k++) begin
            checkOutput("t2_drain_byte", tx_data, 8'(8'h10 + k));
            busRead(IDLE_ADDR, 1'b1);
        end
        checkOutput("t2_drained", tx_valid, 1'b0);

        // Push plus pop on a full FIFO
        doReset();
        for (int i = 0; i < 16; i++) busWrite(32'h0003_0000, 8'(i), 1'b0);
        busWrite(32'h0003_0000, 8'hEE, 1'b1);
        checkOutput("t3_no_ovf", tx_overflow, 1'b0);
        checkOutput("t3_still_full", io_buffer_full, 1'b1);
        for (int k = 0; k < 15; k++) busRead(IDLE_ADDR, 1'b1);
        checkOutput("t3_last_byte", tx_data, 8'hEE);
        busRead(IDLE_ADDR, 1'b1);
        checkOutput("t3_empty", tx_valid, 1'b0);

        // RX capture and read bursts
        applyStimulus(1'b0, 1'b0, IDLE_ADDR, 8'h00, 1'b0, 1'b1, 8'h41);
        checkOutput("t4_rx_ready_low", rx_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            busRead(32'h0003_0000, 1'b0);
            checkOutput("t4_burst_byte", ram_r_data, 8'h41);
        end
        busRead(IDLE_ADDR, 1'b0);
        busRead(32'h0003_0000, 1'b0);
        checkOutput("t4_second_burst", ram_r_data, 8'h00);
        checkOutput("t4_rx_ready_high", rx_ready, 1'b1);

        // Status register
        applyStimulus(1'b0, 1'b0, IDLE_ADDR, 8'h00, 1'b0, 1'b1, 8'h5A);
        for (int i = 0; i < 14; i++) busWrite(32'h0003_0000, 8'(8'h80 + i), 1'b0);
        busRead(32'h0003_0004, 1'b0);
        checkOutput("t5_status", ram_r_data, 8'h03);

        // Sim-end port and reset during drain
        busWrite(32'h0003_0004, 8'hA5, 1'b0);
        checkOutput("t6_done_pulse", program_done, 1'b1);
        checkOutput("t6_exit_code", exit_code, 8'hA5);
        busRead(IDLE_ADDR, 1'b1);
        checkOutput("t6_done_cleared", program_done, 1'b0);
        checkOutput("t6_exit_held", exit_code, 8'hA5);
        busRead(IDLE_ADDR, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0003_0004, 8'h77, 1'b1, 1'b0, 8'h00);
        checkOutput("t6_rst_tx_valid", tx_valid, 1'b0);
        checkOutput("t6_rst_buf_full", io_buffer_full, 1'b0);
        checkOutput("t6_rst_no_done", program_done, 1'b0);

        // Randomized traffic; repeated addresses form read bursts
        for (int i = 0; i < 8; i++) busWrite(pool[i], 8'($urandom()), 1'b0);
        a = IDLE_ADDR; rw = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) >= 4) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 4)      a = pool[$urandom_range(0, 7)] | ($urandom() & 32'hFFFC_0000);
                else if (sel < 7) a = 32'h0003_0000 | ($urandom() & 32'hFFFC_FFF8);
                else if (sel < 8) a = 32'h0003_0004 | ($urandom() & 32'hFFFC_FFF8);
                else              a = 32'h0003_0000 | ($urandom() & 32'hFFFC_FFFF);
                rw = 1'($urandom_range(0, 1));
            end
            r   = ($urandom_range(0, 199) == 0);
            wd  = 8'($urandom());
            txr = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 3) == 0);
            rd  = 8'($urandom());
            applyStimulus(r, r ? 1'b0 : rw, a, wd, txr, rv, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
